// File: rtl/air_hockey_pkg.sv
// Shared types and constants for the air-hockey puck datapath.
// Optional goal feature is selected with the PUCK_GOAL_EN macro (see puck_motion_ctrl).
package air_hockey_pkg;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  localparam logic [2:0] COLOUR_WHITE = 3'b111;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ERASE  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DRAW   = 2'd3
  } state_e;

  // Direction per axis: POS moves toward larger coordinates.
  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

endpackage

// File: rtl/puck_motion_ctrl_if.sv
// Frame-tick input and plot-port/status bundle of the puck controller.
// Handshake: there is no backpressure. A frame request is accepted only when
// enable & frame_tick are both high while busy is low; otherwise it is dropped.
// Each cycle with plot=1 carries one pixel write (x_out, y_out, colour) that the
// frame buffer must take in that same cycle.
interface puck_motion_ctrl_if;
  import air_hockey_pkg::*;

  logic       enable;
  logic       frame_tick;
  logic [8:0] x_out;
  logic [7:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       bounce;
  logic       score_l;
  logic       score_r;
  logic [8:0] puck_x;
  logic [7:0] puck_y;
  state_e     dbg_state;

  // Tick source / frame buffer side
  modport master (
    output enable, frame_tick,
    input  x_out, y_out, colour, plot, busy, bounce, score_l, score_r,
           puck_x, puck_y, dbg_state
  );

  // Puck controller side
  modport slave (
    input  enable, frame_tick,
    output x_out, y_out, colour, plot, busy, bounce, score_l, score_r,
           puck_x, puck_y, dbg_state
  );
endinterface

// File: rtl/puck_bounce.sv
// One axis of puck motion: step by STEP, reflecting off the 0 and limit walls.
// Arithmetic is 10-bit unsigned so pos+SIZE+STEP never wraps.
module puck_bounce
  import air_hockey_pkg::*;
#(
  parameter int PW   = 9,
  parameter int SIZE = 4,
  parameter int STEP = 1
) (
  input  logic [PW-1:0] i_pos,
  input  dir_e          i_dir,
  input  logic [9:0]    i_limit,
  output logic [PW-1:0] o_pos,
  output dir_e          o_dir,
  output logic          o_flip
);
  logic [9:0] w_pos10;
  assign w_pos10 = 10'(i_pos);

  // Next position and direction; clamps to the wall on a reflection
  always_comb begin
    o_pos  = PW'(w_pos10 + 10'(STEP));
    o_dir  = i_dir;
    o_flip = 1'b0;
    if (i_dir == DIR_POS) begin
      if (w_pos10 + 10'(SIZE) + 10'(STEP) > i_limit) begin
        o_dir  = DIR_NEG;
        o_pos  = PW'(i_limit - 10'(SIZE));
        o_flip = 1'b1;
      end
    end else begin
      if (w_pos10 < 10'(STEP)) begin
        o_dir  = DIR_POS;
        o_pos  = '0;
        o_flip = 1'b1;
      end else begin
        o_pos  = PW'(w_pos10 - 10'(STEP));
      end
    end
  end
endmodule

// File: rtl/puck_motion_ctrl.sv
// Per-frame puck sequencer: erase old box, step/reflect, redraw.
// Define PUCK_GOAL_EN to turn side-wall hits inside the goal mouth into scores.
module puck_motion_ctrl
  import air_hockey_pkg::*;
#(
  parameter int         SCREEN_W    = SCREEN_W_DEF,
  parameter int         SCREEN_H    = SCREEN_H_DEF,
  parameter int         SIZE        = 4,
  parameter int         STEP        = 1,
  parameter int         START_X     = 158,
  parameter int         START_Y     = 118,
  parameter logic [2:0] PUCK_COLOUR = COLOUR_WHITE,
  parameter logic [2:0] BG_COLOUR   = COLOUR_BLACK,
  parameter int         GOAL_Y0     = 90,
  parameter int         GOAL_Y1     = 149
) (
  input logic               clock,
  input logic               resetn,
  puck_motion_ctrl_if.slave bus
);
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_ERASE  = ST_ERASE;
  localparam logic [1:0] S_UPDATE = ST_UPDATE;
  localparam logic [1:0] S_DRAW   = ST_DRAW;

  localparam int              LG       = $clog2(SIZE);
  localparam int              CNT_W    = 2 * LG;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE * SIZE - 1);
  localparam logic [9:0]      LIM_X    = 10'(SCREEN_W);
  localparam logic [9:0]      LIM_Y    = 10'(SCREEN_H);

`ifdef PUCK_GOAL_EN
  localparam logic GOAL_EN = 1'b1;
`else
  localparam logic GOAL_EN = 1'b0;
`endif

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [8:0]       r_puck_x;
  logic [7:0]       r_puck_y;
  dir_e             r_dir_x;
  dir_e             r_dir_y;
  logic [8:0]       r_x_out;
  logic [7:0]       r_y_out;
  logic [2:0]       r_colour;
  logic             r_plot;
  logic             r_busy;
  logic             r_bounce;
  logic             r_score_l;
  logic             r_score_r;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [8:0]       w_dx;
  logic [7:0]       w_dy;
  logic [8:0]       w_nx;
  logic [7:0]       w_ny;
  dir_e             w_dir_x;
  dir_e             w_dir_y;
  logic             w_flip_x;
  logic             w_flip_y;
  logic             w_in_mouth;
  logic             w_goal;
  logic [8:0]       w_new_x;
  logic [7:0]       w_new_y;

  puck_bounce #(.PW(9), .SIZE(SIZE), .STEP(STEP)) u_bounce_x (
    .i_pos(r_puck_x), .i_dir(r_dir_x), .i_limit(LIM_X),
    .o_pos(w_nx), .o_dir(w_dir_x), .o_flip(w_flip_x)
  );

  puck_bounce #(.PW(8), .SIZE(SIZE), .STEP(STEP)) u_bounce_y (
    .i_pos(r_puck_y), .i_dir(r_dir_y), .i_limit(LIM_Y),
    .o_pos(w_ny), .o_dir(w_dir_y), .o_flip(w_flip_y)
  );

  // Pixel offset inside the box for the next count value
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_dx      = 9'(w_cnt_nxt[LG-1:0]);
  assign w_dy      = 8'(w_cnt_nxt[CNT_W-1:LG]);

  // Goal: a horizontal reflection with every box row inside the mouth
  assign w_in_mouth = (10'(r_puck_y) >= 10'(GOAL_Y0)) &&
                      (10'(r_puck_y) + 10'(SIZE - 1) <= 10'(GOAL_Y1));
  assign w_goal     = GOAL_EN && w_flip_x && w_in_mouth;
  assign w_new_x    = w_goal ? 9'(START_X) : w_nx;
  assign w_new_y    = w_goal ? 8'(START_Y) : w_ny;

  // Sequencer: state, position and all registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_WAIT;
      r_cnt     <= '0;
      r_puck_x  <= 9'(START_X);
      r_puck_y  <= 8'(START_Y);
      r_dir_x   <= DIR_POS;
      r_dir_y   <= DIR_POS;
      r_x_out   <= '0;
      r_y_out   <= '0;
      r_colour  <= '0;
      r_plot    <= 1'b0;
      r_busy    <= 1'b0;
      r_bounce  <= 1'b0;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
    end else begin
      r_bounce  <= 1'b0;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (bus.enable && bus.frame_tick) begin
            r_state  <= S_ERASE;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_plot   <= 1'b1;
            r_x_out  <= r_puck_x;
            r_y_out  <= r_puck_y;
            r_colour <= BG_COLOUR;
          end
        end
        S_ERASE: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= S_UPDATE;
            r_plot  <= 1'b0;
          end else begin
            r_cnt   <= w_cnt_nxt;
            r_x_out <= r_puck_x + w_dx;
            r_y_out <= r_puck_y + w_dy;
          end
        end
        S_UPDATE: begin
          r_state   <= S_DRAW;
          r_cnt     <= '0;
          r_puck_x  <= w_new_x;
          r_puck_y  <= w_new_y;
          r_dir_x   <= w_dir_x;
          r_dir_y   <= w_dir_y;
          r_plot    <= 1'b1;
          r_x_out   <= w_new_x;
          r_y_out   <= w_new_y;
          r_colour  <= PUCK_COLOUR;
          r_bounce  <= (w_flip_x || w_flip_y) && !w_goal;
          r_score_l <= w_goal && (r_dir_x == DIR_POS);
          r_score_r <= w_goal && (r_dir_x == DIR_NEG);
        end
        S_DRAW: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= S_WAIT;
            r_plot  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= w_cnt_nxt;
            r_x_out <= r_puck_x + w_dx;
            r_y_out <= r_puck_y + w_dy;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  assign bus.x_out     = r_x_out;
  assign bus.y_out     = r_y_out;
  assign bus.colour    = r_colour;
  assign bus.plot      = r_plot;
  assign bus.busy      = r_busy;
  assign bus.bounce    = r_bounce;
  assign bus.score_l   = r_score_l;
  assign bus.score_r   = r_score_r;
  assign bus.puck_x    = r_puck_x;
  assign bus.puck_y    = r_puck_y;
  assign bus.dbg_state = state_e'(r_state);
endmodule

// File: tb/tb_puck_motion_ctrl.sv
// Bench for puck_motion_ctrl: four instances ticked in lockstep
// (centre, right-edge start, 8x8 corner field, narrow field crossing the goal mouth).
module tb_puck_motion_ctrl;
  import air_hockey_pkg::*;

  logic clock;
  logic resetn;

  puck_motion_ctrl_if if_main ();
  puck_motion_ctrl_if if_edge ();
  puck_motion_ctrl_if if_corner ();
  puck_motion_ctrl_if if_goal ();

  puck_motion_ctrl u_main (.clock(clock), .resetn(resetn), .bus(if_main));
  puck_motion_ctrl #(.START_X(315)) u_edge (.clock(clock), .resetn(resetn), .bus(if_edge));
  puck_motion_ctrl #(.SCREEN_W(8), .SCREEN_H(8), .START_X(4), .START_Y(4))
    u_corner (.clock(clock), .resetn(resetn), .bus(if_corner));
  puck_motion_ctrl #(.SCREEN_W(8), .START_X(4), .START_Y(118))
    u_goal (.clock(clock), .resetn(resetn), .bus(if_goal));

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];
  int n_checks = 0;
  int n_bad    = 0;
  int main_x   = 158;
  int main_y   = 118;
  int b_cnt[4];
  int sl_cnt[4];
  int sr_cnt[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic en, input logic tk);
    if_main.enable     = en; if_main.frame_tick   = tk;
    if_edge.enable     = en; if_edge.frame_tick   = tk;
    if_corner.enable   = en; if_corner.frame_tick = tk;
    if_goal.enable     = en; if_goal.frame_tick   = tk;
  endtask

  task automatic count_pulses();
    b_cnt[0]  += int'(if_main.bounce);   sl_cnt[0] += int'(if_main.score_l);   sr_cnt[0] += int'(if_main.score_r);
    b_cnt[1]  += int'(if_edge.bounce);   sl_cnt[1] += int'(if_edge.score_l);   sr_cnt[1] += int'(if_edge.score_r);
    b_cnt[2]  += int'(if_corner.bounce); sl_cnt[2] += int'(if_corner.score_l); sr_cnt[2] += int'(if_corner.score_r);
    b_cnt[3]  += int'(if_goal.bounce);   sl_cnt[3] += int'(if_goal.score_l);   sr_cnt[3] += int'(if_goal.score_r);
  endtask

  // One frame: tick, then follow the main instance's pixel stream until busy drops.
  // inject_at >= 0 raises frame_tick again on that cycle of the sequence.
  task automatic run_frame(input int inject_at);
    int cyc;
    int busy_n;
    int gaps;
    bit done;
    logic [19:0] e;
    for (int c = 0; c < 16; c++)
      exp_q.push_back({9'(main_x + c % 4), 8'(main_y + c / 4), 3'b000});
    for (int c = 0; c < 16; c++)
      exp_q.push_back({9'(main_x + 1 + c % 4), 8'(main_y + 1 + c / 4), 3'b111});
    for (int i = 0; i < 4; i++) begin b_cnt[i] = 0; sl_cnt[i] = 0; sr_cnt[i] = 0; end
    @(negedge clock); set_in(1'b1, 1'b1);
    @(negedge clock); set_in(1'b1, 1'b0);
    cyc = 0; busy_n = 0; gaps = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      if (if_main.busy) busy_n++;
      if (if_main.plot) begin
        if (exp_q.size() == 0) check("main_extra_plot", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("main_pixel", {12'd0, if_main.x_out, if_main.y_out, if_main.colour}, {12'd0, e});
        end
      end else if (if_main.busy) gaps++;
      count_pulses();
      if (!if_main.busy) done = 1'b1;
      set_in(1'b1, (cyc == inject_at) ? 1'b1 : 1'b0);
      cyc++;
      @(negedge clock);
    end
    set_in(1'b1, 1'b0);
    check("frame_done", 32'(done), 32'd1);
    check("busy_cycles", busy_n, 33);
    check("idle_gap", gaps, 1);
    check("pixels_left", exp_q.size(), 0);
    exp_q.delete();
    main_x++; main_y++;
    check("main_puck_x", 32'(if_main.puck_x), main_x);
    check("main_puck_y", 32'(if_main.puck_y), main_y);
    check("main_bounce", b_cnt[0], 0);
  endtask

  // ---------------- hand-computed per-frame tables ----------------
  int corner_p[7] = '{4, 3, 2, 1, 0, 0, 1};
  int corner_b[7] = '{1, 0, 0, 0, 0, 1, 0};
`ifdef PUCK_GOAL_EN
  int edge_x[7]  = '{316, 315, 314, 313, 312, 311, 310};
  int edge_y[7]  = '{119, 118, 119, 120, 121, 122, 123};
  int edge_b[7]  = '{0, 0, 0, 0, 0, 0, 0};
  int edge_sl[7] = '{0, 1, 0, 0, 0, 0, 0};
  int goal_x[7]  = '{4, 3, 2, 1, 0, 4, 4};
  int goal_y[7]  = '{118, 119, 120, 121, 122, 118, 118};
  int goal_b[7]  = '{0, 0, 0, 0, 0, 0, 0};
  int goal_sl[7] = '{1, 0, 0, 0, 0, 0, 1};
  int goal_sr[7] = '{0, 0, 0, 0, 0, 1, 0};
`else
  int edge_x[7]  = '{316, 316, 315, 314, 313, 312, 311};
  int edge_y[7]  = '{119, 120, 121, 122, 123, 124, 125};
  int edge_b[7]  = '{0, 1, 0, 0, 0, 0, 0};
  int edge_sl[7] = '{0, 0, 0, 0, 0, 0, 0};
  int goal_x[7]  = '{4, 3, 2, 1, 0, 0, 1};
  int goal_y[7]  = '{119, 120, 121, 122, 123, 124, 125};
  int goal_b[7]  = '{1, 0, 0, 0, 0, 1, 0};
  int goal_sl[7] = '{0, 0, 0, 0, 0, 0, 0};
  int goal_sr[7] = '{0, 0, 0, 0, 0, 0, 0};
`endif

  // ---------------- main sequence ----------------
  initial begin
    int busy_seen;
    set_in(1'b0, 1'b0);
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Reset state
    check("rst_plot",    32'(if_main.plot), 0);
    check("rst_busy",    32'(if_main.busy), 0);
    check("rst_puck_x",  32'(if_main.puck_x), 158);
    check("rst_puck_y",  32'(if_main.puck_y), 118);
    check("rst_bounce",  32'(if_main.bounce), 0);
    check("rst_score",   32'({if_main.score_l, if_main.score_r}), 0);
    check("rst_xy_col",  32'({if_main.x_out, if_main.y_out, if_main.colour}), 0);
    check("rst_state",   32'(if_main.dbg_state), 32'(ST_WAIT));
    check("rst_edge_x",  32'(if_edge.puck_x), 315);

    // Seven frames: stream on main, wall/corner/goal behaviour on the others
    for (int f = 0; f < 7; f++) begin
      run_frame(-1);
      check("edge_x",    32'(if_edge.puck_x), edge_x[f]);
      check("edge_y",    32'(if_edge.puck_y), edge_y[f]);
      check("edge_bnc",  b_cnt[1], edge_b[f]);
      check("edge_scl",  sl_cnt[1], edge_sl[f]);
      check("corner_x",  32'(if_corner.puck_x), corner_p[f]);
      check("corner_y",  32'(if_corner.puck_y), corner_p[f]);
      check("corner_bnc", b_cnt[2], corner_b[f]);
      check("goal_x",    32'(if_goal.puck_x), goal_x[f]);
      check("goal_y",    32'(if_goal.puck_y), goal_y[f]);
      check("goal_bnc",  b_cnt[3], goal_b[f]);
      check("goal_scl",  sl_cnt[3], goal_sl[f]);
      check("goal_scr",  sr_cnt[3], goal_sr[f]);
    end

    // A tick during DRAW is dropped, not queued
    run_frame(20);
    busy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      busy_seen += int'(if_main.busy);
    end
    check("drop_tick_busy", busy_seen, 0);
    check("drop_tick_x", 32'(if_main.puck_x), main_x);

    // A tick with enable low is ignored
    @(negedge clock); set_in(1'b0, 1'b1);
    @(negedge clock); set_in(1'b0, 1'b0);
    busy_seen = 0;
    repeat (10) begin
      busy_seen += int'(if_main.busy);
      @(negedge clock);
    end
    check("disabled_busy", busy_seen, 0);

    // Reset mid-ERASE takes effect immediately
    @(negedge clock); set_in(1'b1, 1'b1);
    @(negedge clock); set_in(1'b1, 1'b0);
    repeat (4) @(negedge clock);
    check("mid_erase_plot", 32'(if_main.plot), 1);
    #2 resetn = 1'b0;
    #1;
    check("arst_plot",   32'(if_main.plot), 0);
    check("arst_busy",   32'(if_main.busy), 0);
    check("arst_puck_x", 32'(if_main.puck_x), 158);
    check("arst_puck_y", 32'(if_main.puck_y), 118);
    check("arst_state",  32'(if_main.dbg_state), 32'(ST_WAIT));
    check("arst_corner", 32'({if_corner.puck_x, if_corner.puck_y}), 32'({9'd4, 8'd4}));
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("post_rst_busy", 32'(if_main.busy), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
